fall_detect_ctrl: RTL and testbench
===================================

# fall_detect_ctrl

Fall-decision controller for the accelerometer path. It accepts raw 3-axis samples, feeds them to an internal `fall_detect_mag_sq` instance, and runs a free-fall → impact → stillness state machine on the resulting squared magnitude. It raises a latched alarm plus a one-cycle pulse when a complete fall signature is seen. It sits between the sensor-sample interface and the alarm/report logic.

## Interface
Parameters:
- `FF_MIN`, default 4: consecutive free-fall samples required.
- `IMPACT_WIN`, default 8: maximum number of samples after free-fall in which an impact must occur.
- `STILL_MIN`, default 6: consecutive still samples required to declare a fall.
- `STILL_WIN`, default 16: maximum number of samples spent in the stillness check.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `data_valid` in 1: raw sample strobe.
- `ax`, `ay`, `az` in 16 each: signed raw samples.
- `thr_ff_sq` in 32: free-fall threshold, unsigned.
- `thr_imp_sq` in 32: impact threshold, unsigned.
- `still_lo_sq`, `still_hi_sq` in 32 each: stillness band, unsigned, inclusive.
- `alarm_clr` in 1: synchronous abort/clear.
- `mag_sq` out 32: passthrough of the sub-module result.
- `mag_valid` out 1: passthrough of the sub-module valid.
- `fall_pulse` out 1: one-cycle pulse on alarm entry.
- `fall_alarm` out 1: level output, held while in ALARM.
- `state` out 3: current state encoding, for debug.

## Operation
- All FSM decisions happen only on cycles where `mag_valid`=1. A "sample" means one `mag_valid` beat. The controller does not depend on the sub-module's latency.
- Sample classes, all unsigned compares:
  - LOW: `mag_sq` < `thr_ff_sq`.
  - HIGH: `mag_sq` > `thr_imp_sq`.
  - STILL: `still_lo_sq` ≤ `mag_sq` ≤ `still_hi_sq`.
- Thresholds are read live at each sample. Software changes them only while in IDLE.
- States: IDLE=0, FREEFALL=1, IMPACT_WAIT=2, STILL_CHECK=3, ALARM=4.
- IDLE:
  - LOW → FREEFALL, with `cnt`=1.
  - Any other class → stay in IDLE.
- FREEFALL:
  - LOW → `cnt`++. When `cnt` reaches `FF_MIN` → IMPACT_WAIT with `cnt`=0.
  - Non-LOW → IDLE with `cnt`=0.
- IMPACT_WAIT:
  - HIGH → STILL_CHECK; clear `cnt` and `still_cnt`.
  - Other class → `cnt`++. When `cnt` reaches `IMPACT_WIN` → IDLE.
- STILL_CHECK: `cnt`++ on every sample.
  - STILL → `still_cnt`++. When `still_cnt` reaches `STILL_MIN` → ALARM.
  - Non-STILL → `still_cnt`=0.
  - If `cnt` reaches `STILL_WIN` without meeting `STILL_MIN` → IDLE.
  - If `still_cnt` hits `STILL_MIN` on the same sample that `cnt` hits `STILL_WIN`, ALARM wins.
- ALARM:
  - `fall_alarm`=1. Samples are ignored.
  - Exit only via `alarm_clr` → IDLE.
- `alarm_clr` in any state forces IDLE and clears all counters on that edge. It has priority over a coincident `mag_valid`.
- Counters saturate at their terminal value, so they never wrap. Counter width is `$clog2(max(param))+1`.

## Timing
- Reset values:
  - `state`=IDLE; all counters 0.
  - `fall_pulse`=0, `fall_alarm`=0.
  - `mag_sq`=0, `mag_valid`=0, as reset by the sub-module.
- State and counters are registered on the `clk` edge where `mag_valid`=1. The new `state` is visible the following cycle.
- `fall_pulse` is high for exactly the one cycle after the qualifying STILL sample. `fall_alarm` rises in the same cycle and stays high until the cycle after `alarm_clr`.
- `data_valid` may be asserted every cycle. The controller applies no backpressure.
- Asserting `rst_n`=0 mid-sequence returns everything to the reset values immediately (asynchronous reset). There is no partial state.

## Structure
- The package `fall_detect_pkg` holds:
  - the `fd_state_t` enum (3-bit);
  - the `MAG_W`=32 and `AX_W`=16 constants;
  - the default parameter values.
- Sub-module: the existing `fall_detect_mag_sq`, instantiated once, with its outputs wired directly to `mag_sq`/`mag_valid`.
- The FSM, the sample classifiers and both counters live in `fall_detect_ctrl`.

## Test plan
Common setup: 1 g = 1000 counts; `thr_ff_sq`=250000; `thr_imp_sq`=16000000; still band [810000, 1210000]; default parameters.

1. Full fall: four samples (100,0,0), then one (5000,0,0), then six (1000,0,0) → states 1→2→3→4; `fall_pulse` high for one cycle after the 6th still sample; `fall_alarm`=1 held.
2. Short free-fall: three samples (100,0,0) then (1000,0,0) → back to IDLE; `fall_alarm` stays 0.
3. Missed impact: four LOW samples, then eight (1000,0,0) → IMPACT_WAIT times out to IDLE on the 8th; no alarm.
4. Restless after impact: LOW×4, HIGH, then alternating (1000,0,0)/(2000,0,0) for 16 samples → IDLE at `cnt`=16; no alarm.
5. Clear and abort:
   - In ALARM, `alarm_clr` for one cycle → IDLE and `fall_alarm`=0 the next cycle.
   - In IMPACT_WAIT, `alarm_clr` coincident with a HIGH sample → IDLE, not STILL_CHECK.
6. Async reset: drop `rst_n` mid-STILL_CHECK → all outputs 0 and `state`=0 immediately; after release, a fresh full fall sequence alarms normally.

Source files
------------

// File: rtl/fall_detect_pkg.sv
// Shared types and constants for the fall-detection path.
package fall_detect_pkg;

   localparam int MAG_W = 32;
   localparam int AX_W  = 16;

   localparam int FF_MIN_DEF     = 4;
   localparam int IMPACT_WIN_DEF = 8;
   localparam int STILL_MIN_DEF  = 6;
   localparam int STILL_WIN_DEF  = 16;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_FREEFALL    = 3'd1,
      ST_IMPACT_WAIT = 3'd2,
      ST_STILL_CHECK = 3'd3,
      ST_ALARM       = 3'd4
   } fd_state_t;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/fall_detect_mag_sq.sv
// Registered squared magnitude of a signed 3-axis sample; one cycle of latency.
module fall_detect_mag_sq
   import fall_detect_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   data_valid,
   input  logic signed [AX_W-1:0] ax,
   input  logic signed [AX_W-1:0] ay,
   input  logic signed [AX_W-1:0] az,
   output logic [MAG_W-1:0]       mag_sq,
   output logic                   mag_valid
);

   logic signed [2*AX_W-1:0] sq_x, sq_y, sq_z;
   logic [MAG_W-1:0]         mag_sq_d, mag_sq_q;
   logic                     mag_valid_d, mag_valid_q;

   // Worst case 3 * 2^30 still fits in 32 unsigned bits.
   always_comb begin
      sq_x        = ax * ax;
      sq_y        = ay * ay;
      sq_z        = az * az;
      mag_sq_d    = mag_sq_q;
      mag_valid_d = data_valid;
      if (data_valid)
         mag_sq_d = $unsigned(sq_x) + $unsigned(sq_y) + $unsigned(sq_z);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag_sq_q    <= '0;
         mag_valid_q <= 1'b0;
      end else begin
         mag_sq_q    <= mag_sq_d;
         mag_valid_q <= mag_valid_d;
      end
   end

   assign mag_sq    = mag_sq_q;
   assign mag_valid = mag_valid_q;

endmodule

// File: rtl/fall_detect_ctrl.sv
// Free-fall -> impact -> stillness decision FSM on the squared acceleration magnitude.
module fall_detect_ctrl
   import fall_detect_pkg::*;
#(
   parameter int FF_MIN     = FF_MIN_DEF,
   parameter int IMPACT_WIN = IMPACT_WIN_DEF,
   parameter int STILL_MIN  = STILL_MIN_DEF,
   parameter int STILL_WIN  = STILL_WIN_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   data_valid,
   input  logic signed [AX_W-1:0] ax,
   input  logic signed [AX_W-1:0] ay,
   input  logic signed [AX_W-1:0] az,
   input  logic [MAG_W-1:0]       thr_ff_sq,
   input  logic [MAG_W-1:0]       thr_imp_sq,
   input  logic [MAG_W-1:0]       still_lo_sq,
   input  logic [MAG_W-1:0]       still_hi_sq,
   input  logic                   alarm_clr,
   output logic [MAG_W-1:0]       mag_sq,
   output logic                   mag_valid,
   output logic                   fall_pulse,
   output logic                   fall_alarm,
   output logic [2:0]             state
);

   localparam int CNT_W = $clog2(max4(FF_MIN, IMPACT_WIN, STILL_MIN, STILL_WIN)) + 1;

   fall_detect_mag_sq u_mag_sq (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_valid (data_valid),
      .ax         (ax),
      .ay         (ay),
      .az         (az),
      .mag_sq     (mag_sq),
      .mag_valid  (mag_valid)
   );

   fd_state_t        state_d, state_q;
   logic [CNT_W-1:0] cnt_d, cnt_q, still_d, still_q;
   logic [CNT_W-1:0] cnt_inc, still_inc;
   logic             fall_pulse_d, fall_pulse_q;
   logic             is_low, is_high, is_still;

   always_comb begin
      is_low    = mag_sq < thr_ff_sq;
      is_high   = mag_sq > thr_imp_sq;
      is_still  = (mag_sq >= still_lo_sq) && (mag_sq <= still_hi_sq);
      // Saturating increments; state exits occur before the ceiling is reached.
      cnt_inc   = (&cnt_q)   ? cnt_q   : cnt_q + 1'b1;
      still_inc = (&still_q) ? still_q : still_q + 1'b1;

      state_d      = state_q;
      cnt_d        = cnt_q;
      still_d      = still_q;
      fall_pulse_d = 1'b0;

      if (alarm_clr) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         still_d = '0;
      end else if (mag_valid) begin
         unique case (state_q)
            ST_IDLE: begin
               if (is_low) begin
                  state_d = ST_FREEFALL;
                  cnt_d   = CNT_W'(1);
               end
            end
            ST_FREEFALL: begin
               if (!is_low) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (cnt_inc >= CNT_W'(FF_MIN)) begin
                  state_d = ST_IMPACT_WAIT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_IMPACT_WAIT: begin
               if (is_high) begin
                  state_d = ST_STILL_CHECK;
                  cnt_d   = '0;
                  still_d = '0;
               end else if (cnt_inc >= CNT_W'(IMPACT_WIN)) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_STILL_CHECK: begin
               cnt_d   = cnt_inc;
               still_d = is_still ? still_inc : '0;
               // The stillness condition is checked first so it wins a tie with the window.
               if (is_still && (still_inc >= CNT_W'(STILL_MIN))) begin
                  state_d      = ST_ALARM;
                  fall_pulse_d = 1'b1;
               end else if (cnt_inc >= CNT_W'(STILL_WIN)) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  still_d = '0;
               end
            end
            ST_ALARM: begin
               state_d = ST_ALARM;
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               still_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         still_q      <= '0;
         fall_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         still_q      <= still_d;
         fall_pulse_q <= fall_pulse_d;
      end
   end

   assign state      = state_q;
   assign fall_alarm = (state_q == ST_ALARM);
   assign fall_pulse = fall_pulse_q;

endmodule

// File: tb/tb_fall_detect_ctrl.sv
// Directed bench for fall_detect_ctrl: full fall, early exits, clear and async reset.
module tb_fall_detect_ctrl;
   import fall_detect_pkg::*;

   logic              clk;
   logic              rst_n;
   logic              data_valid;
   logic signed [15:0] ax, ay, az;
   logic [31:0]       thr_ff_sq, thr_imp_sq, still_lo_sq, still_hi_sq;
   logic              alarm_clr;
   logic [31:0]       mag_sq;
   logic              mag_valid;
   logic              fall_pulse;
   logic              fall_alarm;
   logic [2:0]        state;

   int checks = 0;
   int errors = 0;

   fall_detect_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .data_valid  (data_valid),
      .ax          (ax),
      .ay          (ay),
      .az          (az),
      .thr_ff_sq   (thr_ff_sq),
      .thr_imp_sq  (thr_imp_sq),
      .still_lo_sq (still_lo_sq),
      .still_hi_sq (still_hi_sq),
      .alarm_clr   (alarm_clr),
      .mag_sq      (mag_sq),
      .mag_valid   (mag_valid),
      .fall_pulse  (fall_pulse),
      .fall_alarm  (fall_alarm),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One sample: strobe for a cycle, check the magnitude beat, and return
   // at the negedge where the FSM result of that beat is visible.
   task automatic send(input logic signed [15:0] x, input logic signed [15:0] y,
                       input logic signed [15:0] z, input logic [31:0] exp_mag);
      ax = x; ay = y; az = z;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      chk("mag_valid", {31'd0, mag_valid}, 32'd1);
      chk("mag_sq", mag_sq, exp_mag);
      @(negedge clk);
   endtask

   task automatic low();   send(16'sd100,  0, 0, 32'd10000);    endtask
   task automatic high();  send(16'sd5000, 0, 0, 32'd25000000); endtask
   task automatic still(); send(16'sd1000, 0, 0, 32'd1000000);  endtask
   task automatic mid();   send(16'sd2000, 0, 0, 32'd4000000);  endtask

   initial begin
      rst_n = 1'b0; data_valid = 1'b0; alarm_clr = 1'b0;
      ax = 0; ay = 0; az = 0;
      thr_ff_sq = 32'd250000; thr_imp_sq = 32'd16000000;
      still_lo_sq = 32'd810000; still_hi_sq = 32'd1210000;
      repeat (2) @(negedge clk);
      chk("rst_state", {29'd0, state}, 32'd0);
      chk("rst_alarm", {31'd0, fall_alarm}, 32'd0);
      chk("rst_pulse", {31'd0, fall_pulse}, 32'd0);
      chk("rst_mag", mag_sq, 32'd0);
      chk("rst_magv", {31'd0, mag_valid}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1. full fall
      low();  chk("t1_ff1", {29'd0, state}, 32'd1);
      low(); low();
      chk("t1_ff3", {29'd0, state}, 32'd1);
      low();  chk("t1_iw", {29'd0, state}, 32'd2);
      high(); chk("t1_sc", {29'd0, state}, 32'd3);
      for (int i = 0; i < 5; i++) still();
      chk("t1_sc5", {29'd0, state}, 32'd3);
      chk("t1_nopulse", {31'd0, fall_pulse}, 32'd0);
      still();
      chk("t1_alarm_st", {29'd0, state}, 32'd4);
      chk("t1_pulse", {31'd0, fall_pulse}, 32'd1);
      chk("t1_alarm", {31'd0, fall_alarm}, 32'd1);
      @(negedge clk);
      chk("t1_pulse_off", {31'd0, fall_pulse}, 32'd0);
      chk("t1_alarm_held", {31'd0, fall_alarm}, 32'd1);
      low();
      chk("t1_ignored", {29'd0, state}, 32'd4);

      // 5a. clear in ALARM
      alarm_clr = 1'b1;
      @(negedge clk);
      alarm_clr = 1'b0;
      chk("t5_clr_st", {29'd0, state}, 32'd0);
      chk("t5_clr_alarm", {31'd0, fall_alarm}, 32'd0);

      // 2. short free-fall
      low(); low(); low();
      chk("t2_ff", {29'd0, state}, 32'd1);
      still();
      chk("t2_idle", {29'd0, state}, 32'd0);
      chk("t2_alarm", {31'd0, fall_alarm}, 32'd0);

      // 3. missed impact
      repeat (4) low();
      for (int i = 0; i < 7; i++) still();
      chk("t3_iw7", {29'd0, state}, 32'd2);
      still();
      chk("t3_idle", {29'd0, state}, 32'd0);
      chk("t3_alarm", {31'd0, fall_alarm}, 32'd0);

      // 4. restless after impact
      repeat (4) low();
      high();
      for (int i = 0; i < 15; i++) begin
         if (i % 2 == 0) still(); else mid();
      end
      chk("t4_sc15", {29'd0, state}, 32'd3);
      mid();
      chk("t4_idle", {29'd0, state}, 32'd0);
      chk("t4_alarm", {31'd0, fall_alarm}, 32'd0);

      // 5b. clear coincident with HIGH beat in IMPACT_WAIT
      repeat (4) low();
      chk("t5_iw", {29'd0, state}, 32'd2);
      ax = 16'sd5000; ay = 0; az = 0;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      alarm_clr = 1'b1;
      chk("t5_hi_beat", {31'd0, mag_valid}, 32'd1);
      @(negedge clk);
      alarm_clr = 1'b0;
      chk("t5_clr_prio", {29'd0, state}, 32'd0);
      @(negedge clk);
      chk("t5_stay_idle", {29'd0, state}, 32'd0);

      // 6. async reset mid-STILL_CHECK
      repeat (4) low();
      high();
      still(); still();
      chk("t6_sc", {29'd0, state}, 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_state", {29'd0, state}, 32'd0);
      chk("t6_rst_mag", mag_sq, 32'd0);
      chk("t6_rst_magv", {31'd0, mag_valid}, 32'd0);
      chk("t6_rst_alarm", {31'd0, fall_alarm}, 32'd0);
      chk("t6_rst_pulse", {31'd0, fall_pulse}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      repeat (4) low();
      high();
      repeat (6) still();
      chk("t6_alarm_st", {29'd0, state}, 32'd4);
      chk("t6_pulse", {31'd0, fall_pulse}, 32'd1);
      chk("t6_alarm", {31'd0, fall_alarm}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
